// File: rtl/riscat_pkg.sv
// Shared types and sizing for the RV32I integer register file.
package riscat_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam reg_addr_t LAST_REG = reg_addr_t'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority and two lookups.
// Optional REGFILE_BYPASS_EN hides busy for a register being written this cycle.
module regfile_scoreboard
  import riscat_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      run,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Set is applied after clear so a freshly issued producer wins.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (run) begin
      busy <= busy_next;
    end
  end

  always_comb begin
    rs1_busy = run && busy[rs1_addr];
    rs2_busy = run && busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (clr_en && clr_addr == rs1_addr) rs1_busy = 1'b0;
    if (clr_en && clr_addr == rs2_addr) rs2_busy = 1'b0;
`endif
  end

endmodule

// File: rtl/register_file.sv
// 32 x XLEN register file: zero-sweep init FSM, two registered read ports, busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads and write-aware busy reporting.
module register_file
  import riscat_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  xlen_t     wr_data,
  input  logic      rd_req,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output xlen_t     rs1_data,
  output xlen_t     rs2_data,
  output logic      rd_valid,
  input  logic      busy_set_en,
  input  reg_addr_t busy_set_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      init_done
);

  rf_state_t state;
  reg_addr_t sweep_idx;
  logic      run;

  assign run       = (state == RF_RUN);
  assign init_done = run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RF_INIT;
      sweep_idx <= '0;
    end else if (!run) begin
      sweep_idx <= sweep_idx + reg_addr_t'(1);
      if (sweep_idx == LAST_REG) state <= RF_RUN;
    end
  end

  // The sweep and writeback share the single write port; the sweep owns it during INIT.
  xlen_t     mem [NUM_REGS];
  logic      mem_we;
  reg_addr_t mem_waddr;
  xlen_t     mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (!run) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_idx;
        mem_wdata = '0;
      end else if (wr_en && wr_addr != '0) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: storage has no reset so it maps onto RAM; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  xlen_t rs1_next;
  xlen_t rs2_next;

  always_comb begin
    rs1_next = mem[rs1_addr];
    rs2_next = mem[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == rs1_addr) rs1_next = wr_data;
    if (wr_en && wr_addr == rs2_addr) rs2_next = wr_data;
`endif
    if (rs1_addr == '0) rs1_next = '0;
    if (rs2_addr == '0) rs2_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      rd_valid <= run && rd_req;
      if (run && rd_req) begin
        rs1_data <= rs1_next;
        rs2_data <= rs2_next;
      end
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .set_en   (busy_set_en),
    .set_addr (busy_set_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array-level model, plus directed literal checks.
module tb_register_file;
  import riscat_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      wr_en = 1'b0;
  reg_addr_t wr_addr = '0;
  xlen_t     wr_data = '0;
  logic      rd_req = 1'b0;
  reg_addr_t rs1_addr = '0;
  reg_addr_t rs2_addr = '0;
  logic      busy_set_en = 1'b0;
  reg_addr_t busy_set_addr = '0;
  xlen_t     rs1_data;
  xlen_t     rs2_data;
  logic      rd_valid;
  logic      rs1_busy;
  logic      rs2_busy;
  logic      init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_req        (rd_req),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rd_valid      (rd_valid),
    .busy_set_en   (busy_set_en),
    .busy_set_addr (busy_set_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .init_done     (init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: registers as a plain array, busy as a bit set, INIT as a 32-cycle countdown.
  bit [31:0]         m_mem [NUM_REGS];
  bit [NUM_REGS-1:0] m_busy;
  bit                m_run;
  bit                m_known;
  bit                m_valid;
  bit [31:0]         m_rs1;
  bit [31:0]         m_rs2;
  int                m_cnt;

  function automatic bit [31:0] m_read(input reg_addr_t a);
    if (a == '0) return 32'h0;
    if (BYPASS && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input reg_addr_t a);
    if (!m_run || a == '0) return 1'b0;
    if (BYPASS && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_known <= 1'b1;
      m_run   <= 1'b0;
      m_cnt   <= 0;
      m_busy  <= '0;
      m_valid <= 1'b0;
      m_rs1   <= 32'h0;
      m_rs2   <= 32'h0;
    end else if (!m_run) begin
      m_valid <= 1'b0;
      m_cnt   <= m_cnt + 1;
      if (m_cnt == NUM_REGS - 1) begin
        m_run <= 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_mem[i] <= 32'h0;
      end
    end else begin
      m_valid <= rd_req;
      if (rd_req) begin
        m_rs1 <= m_read(rs1_addr);
        m_rs2 <= m_read(rs2_addr);
      end
      if (wr_en && wr_addr != '0) m_mem[wr_addr] <= wr_data;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (busy_set_en && busy_set_addr == reg_addr_t'(i)) m_busy[i] <= 1'b1;
        else if (wr_en && wr_addr == reg_addr_t'(i))        m_busy[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("init_done", 32'(init_done), 32'(m_run));
      check("rd_valid",  32'(rd_valid),  32'(m_valid));
      check("rs1_data",  rs1_data,       m_rs1);
      check("rs2_data",  rs2_data,       m_rs2);
      check("rs1_busy",  32'(rs1_busy),  32'(exp_busy(rs1_addr)));
      check("rs2_busy",  32'(rs2_busy),  32'(exp_busy(rs2_addr)));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en       = 1'b0;
    rd_req      = 1'b0;
    busy_set_en = 1'b0;
  endtask

  function automatic reg_addr_t rand_addr();
    if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, NUM_REGS - 1));
    return reg_addr_t'($urandom_range(0, 7));
  endfunction

  task automatic drive_random();
    wr_en         = 1'($urandom_range(0, 1));
    wr_addr       = rand_addr();
    wr_data       = $urandom;
    rd_req        = 1'($urandom_range(0, 1));
    rs1_addr      = rand_addr();
    rs2_addr      = rand_addr();
    busy_set_en   = 1'($urandom_range(0, 2) == 0);
    busy_set_addr = rand_addr();
  endtask

  // Counts edges until init_done rises, with a hard budget; inputs stay random to prove they are ignored.
  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      drive_random();
      cycle();
      n++;
    end
    idle();
  endtask

  initial begin
    int n;
    repeat (2) cycle();
    reset = 1'b0;
    wait_init(n);
    check("init_cycles", 32'(n), 32'd32);

    // All registers read back as zero after the sweep.
    for (int i = 1; i < NUM_REGS; i++) begin
      rd_req   = 1'b1;
      rs1_addr = reg_addr_t'(i);
      rs2_addr = reg_addr_t'(NUM_REGS - i);
      cycle();
      check("sweep_zero_rs1", rs1_data, 32'h0);
      check("sweep_zero_valid", 32'(rd_valid), 32'd1);
    end
    idle();
    cycle();
    check("valid_drops", 32'(rd_valid), 32'd0);

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    rd_req = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    cycle();
    idle();
    check("x5_read", rs1_data, 32'hDEADBEEF);
    check("x0_port2", rs2_data, 32'h0);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    cycle();
    idle();
    rd_req = 1'b1; rs1_addr = 5'd0;
    cycle();
    idle();
    check("x0_write_discard", rs1_data, 32'h0);
    busy_set_en = 1'b1; busy_set_addr = 5'd0;
    cycle();
    idle();
    rs1_addr = 5'd0;
    #1;
    check("x0_never_busy", 32'(rs1_busy), 32'd0);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    cycle();
    wr_data = 32'h22; rd_req = 1'b1; rs1_addr = 5'd7;
    cycle();
    idle();
    check("same_cycle_rw", rs1_data, BYPASS ? 32'h22 : 32'h11);

    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    cycle();
    idle();
    rs1_addr = 5'd9;
    #1;
    check("busy_set", 32'(rs1_busy), 32'd1);
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    cycle();
    idle();
    #1;
    check("set_wins", 32'(rs1_busy), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9;
    cycle();
    idle();
    #1;
    check("write_clears", 32'(rs1_busy), 32'd0);

    // Reset during a read, then again part-way through the sweep.
    rd_req = 1'b1; rs1_addr = 5'd5; reset = 1'b1;
    cycle();
    idle();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rs1_data", rs1_data, 32'h0);
    check("rst_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    check("midsweep_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    wait_init(n);
    check("resweep_cycles", 32'(n), 32'd32);
    rd_req = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd7;
    cycle();
    idle();
    check("resweep_x5", rs1_data, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    repeat (40) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
